run_ctrl: RTL
=============

# run_ctrl

Run controller for the 3BC processor. It turns the testbench `Start`/`Ack` handshake into program-counter control: it loads the PC with the selected program's entry address, then gates PC advance and architectural writes. Load/store instructions are stretched by a fixed data-memory latency. The block also keeps cycle and instruction counts for each run. It sits between the top-level ports and the `ProgCtr`/`Ctrl`/`RegFile`/`DataMem` path, and replaces the free-running PC enable.

## Interface
Parameters:
- `PC_W`, 10, width of PC and entry addresses
- `MEM_LAT`, 1, extra stall cycles per load/store (0..7)
- `PROG_BASE0`, 10'd0, entry address for program 0
- `PROG_BASE1`, 10'd0, entry address for program 1
- `PROG_BASE2`, 10'd0, entry address for program 2
- `PROG_BASE3`, 10'd0, entry address for program 3

Ports:
- `Clk`  in  1  clock, posedge used
- `Reset`  in  1  reset, asynchronous, active-low
- `Start`  in  1  testbench start level
- `ProgSel`  in  2  program index, sampled at launch
- `HaltInst`  in  1  current instruction is halt (from Ctrl)
- `MemInst`  in  1  current instruction is load or store (from Ctrl)
- `PcEn`  out  1  advance PC at the next edge
- `PcLoad`  out  1  load PC with `PcInit` at the next edge
- `PcInit`  out  PC_W  entry address of the latched program
- `WrGate`  out  1  qualifies RegWrEn and StoreInst
- `Ack`  out  1  program finished
- `CycleCt`  out  16  cycles in the current/last run
- `InstCt`  out  16  instructions retired in the current/last run

## Operation
- States: IDLE, ARMED, LAUNCH, RUN, STALL, DONE.
- Reset low → IDLE immediately. All outputs 0, counters 0, latched select 0, wait counter 0.
- IDLE/DONE: `Start`=1 → ARMED.
- ARMED: waits for `Start`=0. Then it latches `ProgSel` → LAUNCH.
- LAUNCH (1 cycle): `PcLoad`=1, `PcInit`=PROG_BASE[sel]. Both counters clear to 0. → RUN.
- RUN, priority order:
  1. `Start`=1 → ARMED (abort). `PcEn`=0, `WrGate`=0.
  2. `HaltInst` → DONE. `PcEn`=0, `WrGate`=0.
  3. `MemInst` with MEM_LAT>0 → STALL. Wait counter loads MEM_LAT−1. `PcEn`=0, `WrGate`=0.
  4. Otherwise `PcEn`=1, `WrGate`=1.
- STALL: `Start`=1 aborts to ARMED. While wait counter ≠0, it decrements, `PcEn`=0, `WrGate`=0. When the counter is 0, `PcEn`=1, `WrGate`=1 → RUN.
- Memory instruction total occupancy = MEM_LAT+1 cycles. Writes commit only in the final cycle.
- With MEM_LAT=0, memory instructions are single-cycle.
- `Ack`=1 only in DONE.
- `PcInit` holds the latched entry address in every state. It is 0 after reset.
- CycleCt: +1 on every RUN/STALL cycle, including the halt cycle.
- InstCt: +1 on every `PcEn`=1 cycle, plus 1 on the halt cycle.
- Both counters saturate at 16'hFFFF. They hold in IDLE/ARMED/DONE and keep their values after an abort until the next LAUNCH.
- Outputs are decoded from registered state and current inputs. `PcEn`/`WrGate` are combinational on `HaltInst`/`MemInst`/`Start`. `Ack` is a registered-state decode.

## Timing
- Launch latency: `Start` falling edge sampled at edge N gives LAUNCH in cycle N+1. First instruction fetched from PROG_BASE is in RUN at cycle N+2.
- Halt seen at edge M → `Ack`=1 from cycle M+1 until the edge after `Start` is sampled high.
- `Start` held high across many cycles keeps the block in ARMED. There is no launch until it falls.
- Reset assertion mid-RUN/STALL drops `PcEn`/`WrGate`/`Ack` asynchronously the same cycle.
- `HaltInst` and `MemInst` both high: halt wins, with no stall.
- `ProgSel` changes after launch have no effect until the next launch.

## Test plan
- Reset low 3 cycles, release → all outputs 0, state IDLE. `Start` 1→0 with `ProgSel`=2, PROG_BASE2=10'd64 → `PcLoad`=1 with `PcInit`=64 one cycle after the fall, `PcEn`=1 the next cycle.
- RUN 5 ALU instructions then `HaltInst` → `Ack`=1 the cycle after halt, CycleCt=6, InstCt=6, `PcEn` stays 0.
- MEM_LAT=2: one `MemInst` held 3 cycles → `PcEn`/`WrGate` = 0,0,1 across those cycles. CycleCt grows by 3, InstCt by 1.
- `Start`=1 during STALL → next cycle ARMED with `PcEn`=0. `Start`=0 → relaunch, counters cleared to 0.
- Reset low mid-STALL → `PcEn`, `WrGate`, `Ack` go to 0 before the next edge. After release the block stays IDLE, with no PC advance until a `Start` pulse.
- `HaltInst`=`MemInst`=1 in RUN → DONE next cycle with no stall cycles. Run 70000 non-halt cycles → CycleCt stays at 16'hFFFF.

Source files
------------

// File: rtl/run_ctrl.sv
// Run controller: turns the Start/Ack handshake into PC load/advance control,
// stretches load/store by MEM_LAT stall cycles and keeps per-run cycle/instruction counts.
module run_ctrl #(
    parameter int              PC_W       = 10,
    parameter int              MEM_LAT    = 1,
    parameter logic [PC_W-1:0] PROG_BASE0 = '0,
    parameter logic [PC_W-1:0] PROG_BASE1 = '0,
    parameter logic [PC_W-1:0] PROG_BASE2 = '0,
    parameter logic [PC_W-1:0] PROG_BASE3 = '0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [1:0]      ProgSel,
    input  logic            HaltInst,
    input  logic            MemInst,
    output logic            PcEn,
    output logic            PcLoad,
    output logic [PC_W-1:0] PcInit,
    output logic            WrGate,
    output logic            Ack,
    output logic [15:0]     CycleCt,
    output logic [15:0]     InstCt
);

    typedef enum logic [2:0] {IDLE, ARMED, LAUNCH, RUN, STALL, DONE} state_t;

    localparam logic [2:0] WAIT_INIT = 3'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);
    localparam logic       HAS_LAT   = (MEM_LAT > 0);

    state_t          state, nextState;
    logic [2:0]      waitCt;
    logic [PC_W-1:0] pcInitQ;
    logic            latchSel, waitLoad, waitDec, haltCyc;
    logic [PC_W-1:0] selBase;

    always_comb begin
        case (ProgSel)
            2'd0:    selBase = PROG_BASE0;
            2'd1:    selBase = PROG_BASE1;
            2'd2:    selBase = PROG_BASE2;
            default: selBase = PROG_BASE3;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        PcEn      = 1'b0;
        WrGate    = 1'b0;
        PcLoad    = 1'b0;
        latchSel  = 1'b0;
        waitLoad  = 1'b0;
        waitDec   = 1'b0;
        haltCyc   = 1'b0;
        case (state)
            IDLE, DONE: if (Start) nextState = ARMED;
            ARMED: begin
                if (!Start) begin
                    latchSel  = 1'b1;
                    nextState = LAUNCH;
                end
            end
            LAUNCH: begin
                PcLoad    = 1'b1;
                nextState = RUN;
            end
            RUN: begin
                // Abort beats halt, halt beats the memory stall.
                if (Start) nextState = ARMED;
                else if (HaltInst) begin
                    haltCyc   = 1'b1;
                    nextState = DONE;
                end else if (MemInst && HAS_LAT) begin
                    waitLoad  = 1'b1;
                    nextState = STALL;
                end else begin
                    PcEn   = 1'b1;
                    WrGate = 1'b1;
                end
            end
            STALL: begin
                if (Start) nextState = ARMED;
                else if (waitCt != 3'd0) waitDec = 1'b1;
                else begin
                    PcEn      = 1'b1;
                    WrGate    = 1'b1;
                    nextState = RUN;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            waitCt  <= '0;
            pcInitQ <= '0;
        end else begin
            if (waitLoad)     waitCt <= WAIT_INIT;
            else if (waitDec) waitCt <= waitCt - 3'd1;
            if (latchSel) pcInitQ <= selBase;
        end
    end

    // Counters clear on launch and only move while the program is executing.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            CycleCt <= '0;
            InstCt  <= '0;
        end else if (state == LAUNCH) begin
            CycleCt <= '0;
            InstCt  <= '0;
        end else if (state == RUN || state == STALL) begin
            if (CycleCt != 16'hFFFF) CycleCt <= CycleCt + 16'd1;
            if ((PcEn || haltCyc) && InstCt != 16'hFFFF) InstCt <= InstCt + 16'd1;
        end
    end

    assign PcInit = pcInitQ;
    assign Ack    = (state == DONE);

endmodule
